// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if
// Requester handshake plus the shared Text LCD pins driven by lcd_bus_arbiter.
// master: requester side (drives REQ_*), slave: the arbiter itself.
interface lcd_bus_arbiter_if;
   logic [2:0]  REQ_VALID;
   logic [2:0]  REQ_RS;
   logic [23:0] REQ_DATA;
   logic [2:0]  REQ_LOCK;
   logic [2:0]  REQ_READY;
   logic [2:0]  GRANT;
   logic        BUSY;
   logic        TLCD_E;
   logic        TLCD_RS;
   logic        TLCD_RW;
   logic [7:0]  TLCD_DATA;

   modport master (
      output REQ_VALID, REQ_RS, REQ_DATA, REQ_LOCK,
      input  REQ_READY, GRANT, BUSY, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA
   );

   modport slave (
      input  REQ_VALID, REQ_RS, REQ_DATA, REQ_LOCK,
      output REQ_READY, GRANT, BUSY, TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
// Shares the Text LCD write bus among three byte requesters (0 font loader,
// 1 text controller, 2 aux status). Each accepted byte runs one timed write:
// SETUP -> PULSE (E high) -> HOLD -> WAIT, with a long wait after clear/home.
// Arbitration is fixed priority (0 highest) unless LCD_ARB_ROUND_ROBIN_EN is
// defined, which selects round-robin starting after the last accepted index.
// An owner holding REQ_LOCK keeps the grant across bytes and burst gaps.
module lcd_bus_arbiter #(
   parameter int E_SETUP_CYC   = 2,
   parameter int E_HIGH_CYC    = 25,
   parameter int E_HOLD_CYC    = 2,
   parameter int CMD_WAIT_CYC  = 2000,
   parameter int LONG_WAIT_CYC = 80000
) (
   input logic              CLK,
   input logic              RST,
   lcd_bus_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(LONG_WAIT_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(E_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(E_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(E_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [2:0]       grant_r;
   logic [2:0]       grant_s;
   logic [2:0]       winner_s;
   logic [2:0]       ready_s;
   logic             accept_s;
   logic             arb_slot_s;
   logic             owner_locked_s;
   logic             rs_r;
   logic             rs_s;
   logic [7:0]       data_r;
   logic [7:0]       data_s;
   logic             e_r;
   logic             e_s;
   logic             busy_r;
   logic             busy_s;

   // Clear display / return home need the long busy wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
   endfunction

   // Lowest set index wins.
   function automatic logic [2:0] pick_fixed(input logic [2:0] valid);
      logic [2:0] pick;
      if (valid[0])      pick = 3'b001;
      else if (valid[1]) pick = 3'b010;
      else if (valid[2]) pick = 3'b100;
      else               pick = 3'b000;
      return pick;
   endfunction

`ifdef LCD_ARB_ROUND_ROBIN_EN
   logic [1:0] rr_ptr_r;
   logic [1:0] acc_idx_s;

   function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
      logic [1:0] idx;
      case (oh)
         3'b010:  idx = 2'd1;
         3'b100:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Rotate so the search starts at 'start', pick lowest, rotate back.
   function automatic logic [2:0] pick_rr(input logic [2:0] valid, input logic [1:0] start);
      logic [2:0] rot;
      logic [2:0] pick;
      logic [2:0] res;
      case (start)
         2'd1:    rot = {valid[0], valid[2], valid[1]};
         2'd2:    rot = {valid[1], valid[0], valid[2]};
         default: rot = valid;
      endcase
      pick = pick_fixed(rot);
      case (start)
         2'd1:    res = {pick[1], pick[0], pick[2]};
         2'd2:    res = {pick[0], pick[2], pick[1]};
         default: res = pick;
      endcase
      return res;
   endfunction

   assign acc_idx_s = onehot_idx(ready_s);
   assign winner_s  = pick_rr(bus.REQ_VALID, rr_ptr_r);

   // Round-robin pointer: first index searched next, moves past each accept.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr_r <= 2'd0;
      end else if (accept_s) begin
         rr_ptr_r <= (acc_idx_s == 2'd2) ? 2'd0 : (acc_idx_s + 2'd1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   assign winner_s = pick_fixed(bus.REQ_VALID);
`endif

   // State register: FSM state and the shared down-counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic: each timed phase reloads the counter for the next one.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_SETUP;
               cnt_s   = SETUP_LD;
            end else begin
               state_s = ST_IDLE;
               cnt_s   = cnt_r;
            end
         end
         ST_SETUP: begin
            if (cnt_r == '0) begin
               state_s = ST_PULSE;
               cnt_s   = HIGH_LD;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_r == '0) begin
               state_s = ST_HOLD;
               cnt_s   = HOLD_LD;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_r == '0) begin
               state_s = ST_WAIT;
               cnt_s   = is_long_cmd(rs_r, data_r) ? LONG_LD : CMD_LD;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == '0) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Output logic: accept handshake, grant arbitration, next bus pin values.
   always_comb begin
      ready_s        = 3'b000;
      accept_s       = 1'b0;
      grant_s        = grant_r;
      rs_s           = rs_r;
      data_s         = data_r;
      owner_locked_s = |(grant_r & bus.REQ_LOCK);

      if (state_r == ST_IDLE) begin
         ready_s = grant_r & bus.REQ_VALID;
      end else begin
         ready_s = 3'b000;
      end
      accept_s = |ready_s;

      if (accept_s) begin
         rs_s = |(ready_s & bus.REQ_RS);
      end else begin
         rs_s = rs_r;
      end

      case (ready_s)
         3'b001:  data_s = bus.REQ_DATA[7:0];
         3'b010:  data_s = bus.REQ_DATA[15:8];
         3'b100:  data_s = bus.REQ_DATA[23:16];
         default: data_s = data_r;
      endcase

      // Grant is re-evaluated in idle cycles without an accept, and on the
      // final WAIT cycle so the grant seen in the first idle cycle already
      // reflects the current requests; the running byte keeps its owner.
      arb_slot_s = ((state_r == ST_IDLE) && !accept_s) ||
                   ((state_r == ST_WAIT) && (cnt_r == '0));

      if (arb_slot_s) begin
         if (owner_locked_s) begin
            grant_s = grant_r;
         end else begin
            grant_s = winner_s;
         end
      end else begin
         grant_s = grant_r;
      end

      e_s    = (state_s == ST_PULSE);
      busy_s = (state_s != ST_IDLE);
   end

   // Registered bus pins and status; async reset drops E at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         grant_r <= 3'b000;
         rs_r    <= 1'b0;
         data_r  <= 8'h00;
         e_r     <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         grant_r <= grant_s;
         rs_r    <= rs_s;
         data_r  <= data_s;
         e_r     <= e_s;
         busy_r  <= busy_s;
      end
   end

   // REQ_READY is a same-cycle decode of the registered grant so the
   // requester sees its accept in the first idle cycle.
   assign bus.REQ_READY = ready_s;
   assign bus.GRANT     = grant_r;
   assign bus.BUSY      = busy_r;
   assign bus.TLCD_E    = e_r;
   assign bus.TLCD_RS   = rs_r;
   assign bus.TLCD_RW   = 1'b0;
   assign bus.TLCD_DATA = data_r;

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single Text LCD bus (E/RS/RW/DATA) among three byte-write requesters: custom font loader, text string controller, and an auxiliary status writer. It replaces the static `font_loader_done` output mux in the top level. Each accepted byte becomes one timed write cycle: setup, E pulse, hold, then a post-write busy wait. Grant is by fixed priority, or round-robin when configured, and an owner may lock the bus for multi-byte bursts.

## Interface
Parameters:
- E_SETUP_CYC, 2: cycles RS/DATA are valid before E rises.
- E_HIGH_CYC, 25: E high width in cycles.
- E_HOLD_CYC, 2: cycles RS/DATA are held after E falls.
- CMD_WAIT_CYC, 2000: busy wait after any write except clear/home.
- LONG_WAIT_CYC, 80000: busy wait after clear/home commands (RS=0, DATA 0x01, 0x02 or 0x03).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- REQ_VALID  in  3  per-requester write request; bit 0 is the font loader, bit 1 the text controller, bit 2 aux.
- REQ_RS  in  3  RS value for each requester's byte.
- REQ_DATA  in  24  packed bytes; requester i uses [8i+7:8i].
- REQ_LOCK  in  3  holds the grant across transactions while high.
- REQ_READY  out  3  one-cycle accept pulse to the granted requester.
- GRANT  out  3  one-hot current owner, or 0 when there is none.
- BUSY  out  1  high while a write cycle is in progress.
- TLCD_E  out  1  LCD enable.
- TLCD_RS  out  1  LCD register select.
- TLCD_RW  out  1  always 0 (write only).
- TLCD_DATA  out  8  LCD data bus.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE, arbitration:
  - If a locked owner exists, meaning GRANT≠0 and REQ_LOCK of the owner is high, GRANT stays unchanged, even while that owner's VALID is low.
  - Otherwise GRANT is set to the winner among the asserted REQ_VALID bits. The winner is the lowest index, or the round-robin choice under the macro.
  - If no REQ_VALID bit is asserted, GRANT is 0.
- IDLE, accept:
  - Accept occurs when GRANT[i] and REQ_VALID[i] are both high.
  - On accept, REQ_READY[i] pulses for one cycle, REQ_RS/REQ_DATA of i are latched into the TLCD_RS/TLCD_DATA registers, and the FSM moves to SETUP.
- SETUP, PULSE, HOLD: each counts its parameter in cycles. TLCD_E=1 only in PULSE.
- WAIT:
  - Counts LONG_WAIT_CYC if the latched byte is a clear/home command, otherwise CMD_WAIT_CYC.
  - Then returns to IDLE.
  - TLCD_RS and TLCD_DATA keep their last value until the next accept.
- Requesters hold RS/DATA stable while VALID is high until READY. Dropping VALID before READY cancels the request with no bus activity.
- Lock:
  - Lock is evaluated only in IDLE.
  - Asserting REQ_LOCK without VALID while holding the grant stalls the other requesters. This is legal and is used for burst gaps.
  - Deasserting REQ_LOCK releases the grant for re-arbitration in that same IDLE cycle.
- REQ_LOCK from a non-owner is ignored.
- Counter: a single down-counter, $clog2(LONG_WAIT_CYC+1) bits wide. Every parameter is ≥1.
- Reset values:
  - TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA: 0.
  - REQ_READY, GRANT, BUSY: 0.
  - FSM: IDLE.
  - Round-robin pointer: 0.
- Because reset is asynchronous, reset mid-transaction drops E immediately.

## Timing
Let accept occur in cycle T (REQ_READY high, FSM in IDLE).
- SETUP: T+1 .. T+E_SETUP_CYC.
- PULSE: the next E_HIGH_CYC cycles.
- HOLD: the next E_HOLD_CYC cycles.
- WAIT: the next wait-count cycles.
- Back in IDLE at T+1+E_SETUP_CYC+E_HIGH_CYC+E_HOLD_CYC+wait. With defaults this is T+2030, or T+80030 for clear/home.
- BUSY is high from T+1 through the last WAIT cycle.
- The earliest next REQ_READY is in the first IDLE cycle. Throughput is one byte per 2030 cycles.
- GRANT updates are registered: a new request raised in cycle N, with no lock, shows in GRANT at N+1 and gives REQ_READY at N+1 at the earliest.
- If VALID is simultaneous on multiple requesters, exactly one is granted. The losers see no READY and must keep VALID asserted.

## Configuration
- Macro `LCD_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration. The search starts at the index after the last accepted requester, wrapping 2→0. The pointer updates on every accept.
  - Undefined: fixed priority, with requester 0 highest and requester 2 lowest. No pointer logic is compiled in.

## Test plan
- Single write: REQ_VALID=3'b010, RS=1, DATA=0x41 → READY[1] at T. E high over T+3..T+27 with RS=1 and DATA=0x41. BUSY falls at T+2030.
- Priority: VALID=3'b111, with macro undefined → accepts in order 0, 0, … while requester 0 stays valid. Requester 2 is granted only after requesters 0 and 1 drop.
- Lock burst: requester 1 locks for 4 bytes while requester 0 requests midway → all 4 bytes of requester 1 complete first, then GRANT becomes 3'b001.
- Clear command: RS=0, DATA=0x01 → next accept no earlier than T+80030. A following DATA=0x80 command uses the 2000-cycle wait.
- Round-robin (macro defined): VALID=3'b111 held → accept order 0, 1, 2, 0.
- Reset mid-PULSE: assert RST at T+10 → TLCD_E=0, GRANT=0 and BUSY=0 immediately. After release the FSM is in IDLE and the interrupted byte is not retried.
